uc_secuenciador: RTL and testbench
==================================

Name: uc_secuenciador

Overview:
- Control unit that closes the loop with the single-cycle datapath `microc`.
- Consumes `Opcode` and the registered `zero` flag.
- Produces `s_inc`, `s_inm`, `we`, `wez`, `ALUOp`, plus a PC-enable for the next datapath revision.
- Adds a run/halt/single-step sequencer and a retired-instruction counter, so programs can be started, stopped and stepped from the test bench or a debug port.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- Opcode  input  6  instruction bits [15:10] from the datapath.
- zero  input  1  registered zero flag from the datapath.
- run  input  1  start/resume request, sampled every edge.
- stop  input  1  stop request, sampled every edge.
- step  input  1  execute exactly one instruction while not running.
- s_inc  output  1  1 = PC+1, 0 = jump target.
- s_inm  output  1  1 = immediate operand / immediate format.
- we  output  1  register-file write enable.
- wez  output  1  zero-flag write enable.
- ALUOp  output  3  ALU operation.
- pc_en  output  1  PC load enable.
- halted  output  1  state is HALT.
- busy  output  1  state is RUN.
- illegal  output  1  sticky: an illegal opcode was met.
- instr_count  output  CNT_W  retired-instruction count.

Behaviour:

Reset:
- reset=0 at an edge gives state IDLE, skip=0, illegal=0, instr_count=0.
- Reset has priority over every other input.

Opcode decode (applies only in an execute cycle):
- 1xxxxx, ALU reg: ALUOp=Opcode[4:2], s_inm=0, we=1, wez=1, s_inc=1, pc_en=1.
- 0100xx, load immediate: ALUOp=000 (ALU pass-operand-2 code), s_inm=1, we=1, wez=0, s_inc=1, pc_en=1.
- 000000, j: s_inc=0, pc_en=1, we=0, wez=0.
- 000001, jz: s_inc=~zero, pc_en=1.
- 000010, jnz: s_inc=zero, pc_en=1.
- 000011, halt: pc_en=0, no writes, next state HALT.
- Any other opcode is illegal: treated as halt and sets illegal=1 (sticky).
- Jumps drive we=0, wez=0, s_inm=0, ALUOp=000.

Non-execute cycles:
- we=0, wez=0, pc_en=0, s_inc=1, s_inm=0, ALUOp=000.
- Outputs are combinational (Mealy) from state, skip, inputs and Opcode.

Execute cycle:
- A cycle is an execute cycle when state=RUN, or when step=1 in IDLE/HALT with stop=0 and run=0.

State IDLE:
- run=1 moves to RUN at the next edge. The run cycle itself does not execute.
- step=1 executes one instruction and stays in IDLE, unless the instruction is halt/illegal, which goes to HALT.
- stop has no effect.
- Priority: stop > run > step.

State RUN:
- Executes one instruction per cycle.
- stop=1: the current instruction still executes, then the state goes to HALT.
- A halt/illegal opcode goes to HALT with the PC left on that instruction.
- run and step are ignored.

State HALT:
- run=1 goes to RUN and sets skip=1.
- step=1 executes the instruction at PC; the state stays HALT.
- Priority: stop > run > step. stop=1 with step=1 executes nothing.

Leaving a halt:
- With skip=1 in RUN, or on a step in HALT, a halt/illegal opcode at PC is executed as a NOP: pc_en=1, s_inc=1, no writes. This prevents re-halting on the same instruction.
- skip clears after the first RUN cycle.

instr_count:
- Increments by 1 at the edge ending every execute cycle whose pc_en=1.
- A halt that stops execution is not counted. A halt/illegal skipped as a NOP is counted.
- Wraps from 2^CNT_W-1 to 0.

Status outputs:
- busy=1 only in RUN; halted=1 only in HALT; both are 0 in IDLE.

Test Plan:
- Release reset, hold run=0 for 5 cycles with Opcode=100100: we, wez and pc_en stay 0, instr_count=0, busy=0, halted=0.
- Pulse run, then feed 3 cycles of Opcode=101000 then 000011: ALUOp=010, we=1, wez=1 on each ALU cycle. The halt cycle has pc_en=0, then halted=1 and instr_count=3.
- In RUN with zero=1, present jz (000001) then jnz (000010): s_inc=0 on jz and s_inc=1 on jnz, with pc_en=1 on both.
- In HALT with Opcode=000011, pulse step once: pc_en=1, s_inc=1, we=0, state stays HALT, instr_count +1. Then assert step and stop together: pc_en=0.
- In RUN, present Opcode=011000: illegal=1 and halted=1. Pulse run: the first cycle acts as a NOP with pc_en=1. Assert reset=0: illegal=0 and instr_count=0.
- With CNT_W=4, execute 16 ALU instructions: instr_count goes 15 then 0. Assert stop mid-run: the instruction in the stop cycle retires, then halted=1.

Source files
------------

// File: rtl/uc_secuenciador.sv
// Control unit for the microc datapath: opcode decode plus a run/halt/single-step
// sequencer and a retired-instruction counter.
module uc_secuenciador #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             zero,
    input  logic             run,
    input  logic             stop,
    input  logic             step,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we,
    output logic             wez,
    output logic [2:0]       ALUOp,
    output logic             pc_en,
    output logic             halted,
    output logic             busy,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e             state_q, state_d;
    logic               skip_q, skip_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic       exec;
    logic       nop_mode;
    logic       halt_like;
    logic       is_illegal;
    logic       halting;
    logic       dec_s_inc, dec_s_inm, dec_we, dec_wez, dec_pc_en;
    logic [2:0] dec_alu;

    always_comb begin
        exec     = (state_q == StRun) || (step && !stop && !run);
        // Leaving a halt: a halt/illegal at PC must not re-halt, so it retires as a NOP.
        nop_mode = (state_q == StRun && skip_q) || (state_q == StHalt);
    end

    always_comb begin
        dec_s_inc  = 1'b1;
        dec_s_inm  = 1'b0;
        dec_we     = 1'b0;
        dec_wez    = 1'b0;
        dec_pc_en  = 1'b0;
        dec_alu    = 3'b000;
        halt_like  = 1'b0;
        is_illegal = 1'b0;
        if (Opcode[5]) begin
            dec_alu   = Opcode[4:2];
            dec_we    = 1'b1;
            dec_wez   = 1'b1;
            dec_pc_en = 1'b1;
        end else if (Opcode[5:2] == 4'b0100) begin
            dec_s_inm = 1'b1;
            dec_we    = 1'b1;
            dec_pc_en = 1'b1;
        end else if (Opcode[5:2] == 4'b0000) begin
            unique case (Opcode[1:0])
                2'b00: begin dec_s_inc = 1'b0;  dec_pc_en = 1'b1; end
                2'b01: begin dec_s_inc = ~zero; dec_pc_en = 1'b1; end
                2'b10: begin dec_s_inc = zero;  dec_pc_en = 1'b1; end
                2'b11: begin halt_like = 1'b1;  dec_pc_en = nop_mode; end
            endcase
        end else begin
            halt_like  = 1'b1;
            is_illegal = 1'b1;
            dec_pc_en  = nop_mode;
        end
    end

    always_comb begin
        s_inc = 1'b1;
        s_inm = 1'b0;
        we    = 1'b0;
        wez   = 1'b0;
        pc_en = 1'b0;
        ALUOp = 3'b000;
        if (exec) begin
            s_inc = dec_s_inc;
            s_inm = dec_s_inm;
            we    = dec_we;
            wez   = dec_wez;
            pc_en = dec_pc_en;
            ALUOp = dec_alu;
        end
    end

    always_comb begin
        halting   = exec && halt_like && !nop_mode;
        state_d   = state_q;
        skip_d    = skip_q;
        illegal_d = illegal_q | (exec && is_illegal);
        count_d   = (exec && dec_pc_en) ? count_q + CNT_W'(1) : count_q;
        unique case (state_q)
            StIdle: begin
                if (!stop && run) begin
                    state_d = StRun;
                end else if (halting) begin
                    state_d = StHalt;
                end
            end
            StRun: begin
                skip_d = 1'b0;
                if (halting || stop) begin
                    state_d = StHalt;
                end
            end
            StHalt: begin
                if (!stop && run) begin
                    state_d = StRun;
                    skip_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            skip_q    <= 1'b0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            skip_q    <= skip_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    assign busy        = (state_q == StRun);
    assign halted      = (state_q == StHalt);
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_uc_secuenciador.sv
// Bench for uc_secuenciador: directed vector table, counter wrap sequence and a
// randomized run against a behavioural model of the sequencer.
module tb_uc_secuenciador;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset, zero, run, stop, step;
    logic [5:0]       Opcode;
    logic             s_inc, s_inm, we, wez, pc_en, halted, busy, illegal;
    logic [2:0]       ALUOp;
    logic [CNT_W-1:0] instr_count;

    int checks = 0;
    int errors = 0;

    uc_secuenciador #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .zero(zero), .run(run),
        .stop(stop), .step(step), .s_inc(s_inc), .s_inm(s_inm), .we(we),
        .wez(wez), .ALUOp(ALUOp), .pc_en(pc_en), .halted(halted), .busy(busy),
        .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rn, sp, st, z;
        logic [5:0] op;
        logic       pc_en, we, wez, s_inc, s_inm;
        logic [2:0] alu;
        logic       busy, halted, ill;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl [20];

    // Model state: 0 idle, 1 run, 2 halt.
    int ms;
    bit mskip, mill;
    int mcnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic rn, input logic sp, input logic st,
                         input logic z, input logic [5:0] op);
        @(posedge clk);
        #1;
        reset = r; run = rn; stop = sp; step = st; zero = z; Opcode = op;
        #3;
    endtask

    function automatic int kind(input logic [5:0] op);
        int v;
        v = int'(op);
        if (v >= 32)          return 0;  // alu
        if ((v >> 2) == 4)    return 1;  // load immediate
        if (v <= 3)           return 2 + v; // j, jz, jnz, halt
        return 6;                         // illegal
    endfunction

    task automatic model_step();
        int  k;
        bit  ex, nopm, e_pc, e_we, e_wez, e_inc, e_inm, stopping;
        int  e_alu;
        k     = kind(Opcode);
        ex    = (ms == 1) || (step && !stop && !run);
        nopm  = (ms == 1 && mskip) || (ms == 2);
        e_pc  = 0; e_we = 0; e_wez = 0; e_inc = 1; e_inm = 0; e_alu = 0;
        if (ex) begin
            case (k)
                0: begin e_alu = int'(Opcode[4:2]); e_we = 1; e_wez = 1; e_pc = 1; end
                1: begin e_inm = 1; e_we = 1; e_pc = 1; end
                2: begin e_inc = 0; e_pc = 1; end
                3: begin e_inc = !zero; e_pc = 1; end
                4: begin e_inc = zero; e_pc = 1; end
                default: e_pc = nopm;
            endcase
        end
        if (reset) begin
            check("rnd pc_en", 32'(pc_en), 32'(e_pc));
            check("rnd we", 32'(we), 32'(e_we));
            check("rnd wez", 32'(wez), 32'(e_wez));
            check("rnd s_inc", 32'(s_inc), 32'(e_inc));
            check("rnd s_inm", 32'(s_inm), 32'(e_inm));
            check("rnd ALUOp", 32'(ALUOp), 32'(e_alu));
        end
        check("rnd busy", 32'(busy), 32'(ms == 1));
        check("rnd halted", 32'(halted), 32'(ms == 2));
        check("rnd illegal", 32'(illegal), 32'(mill));
        check("rnd instr_count", 32'(instr_count), 32'(mcnt));
        if (!reset) begin
            ms = 0; mskip = 0; mill = 0; mcnt = 0;
        end else begin
            stopping = ex && k >= 5 && !nopm;
            if (ex && e_pc) mcnt = (mcnt + 1) % (1 << CNT_W);
            if (ex && k == 6) mill = 1;
            case (ms)
                0: if (!stop && run) ms = 1; else if (stopping) ms = 2;
                1: begin mskip = 0; if (stopping || stop) ms = 2; end
                default: if (!stop && run) begin ms = 1; mskip = 1; end
            endcase
        end
    endtask

    initial begin
        logic [5:0] rop;
        reset = 0; run = 0; stop = 0; step = 0; zero = 0; Opcode = 6'b100100;

        //          rn sp st z  op         pc we wz inc inm alu   bsy hlt ill cnt
        tbl[0]  = '{1, 0, 0, 0, 6'b100100, 0, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 6'b101000, 1, 1, 1, 1, 0, 3'b010, 1, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 6'b101000, 1, 1, 1, 1, 0, 3'b010, 1, 0, 0, 1};
        tbl[3]  = '{0, 0, 0, 0, 6'b101000, 1, 1, 1, 1, 0, 3'b010, 1, 0, 0, 2};
        tbl[4]  = '{0, 0, 0, 0, 6'b000011, 0, 0, 0, 1, 0, 3'b000, 1, 0, 0, 3};
        tbl[5]  = '{0, 0, 0, 0, 6'b000011, 0, 0, 0, 1, 0, 3'b000, 0, 1, 0, 3};
        tbl[6]  = '{0, 0, 1, 0, 6'b000011, 1, 0, 0, 1, 0, 3'b000, 0, 1, 0, 3};
        tbl[7]  = '{0, 1, 1, 0, 6'b000011, 0, 0, 0, 1, 0, 3'b000, 0, 1, 0, 4};
        tbl[8]  = '{1, 0, 0, 1, 6'b000011, 0, 0, 0, 1, 0, 3'b000, 0, 1, 0, 4};
        tbl[9]  = '{0, 0, 0, 1, 6'b000011, 1, 0, 0, 1, 0, 3'b000, 1, 0, 0, 4};
        tbl[10] = '{0, 0, 0, 1, 6'b000001, 1, 0, 0, 0, 0, 3'b000, 1, 0, 0, 5};
        tbl[11] = '{0, 0, 0, 1, 6'b000010, 1, 0, 0, 1, 0, 3'b000, 1, 0, 0, 6};
        tbl[12] = '{0, 0, 0, 0, 6'b010011, 1, 1, 0, 1, 1, 3'b000, 1, 0, 0, 7};
        tbl[13] = '{0, 0, 0, 0, 6'b000000, 1, 0, 0, 0, 0, 3'b000, 1, 0, 0, 8};
        tbl[14] = '{0, 0, 0, 0, 6'b011000, 0, 0, 0, 1, 0, 3'b000, 1, 0, 0, 9};
        tbl[15] = '{0, 0, 0, 0, 6'b011000, 0, 0, 0, 1, 0, 3'b000, 0, 1, 1, 9};
        tbl[16] = '{1, 0, 0, 0, 6'b011000, 0, 0, 0, 1, 0, 3'b000, 0, 1, 1, 9};
        tbl[17] = '{0, 0, 0, 0, 6'b011000, 1, 0, 0, 1, 0, 3'b000, 1, 0, 1, 9};
        tbl[18] = '{0, 1, 0, 0, 6'b100000, 1, 1, 1, 1, 0, 3'b000, 1, 0, 1, 10};
        tbl[19] = '{0, 0, 0, 0, 6'b100000, 0, 0, 0, 1, 0, 3'b000, 0, 1, 1, 11};

        apply(0, 0, 0, 0, 0, 6'b100100);
        for (int i = 0; i < 5; i++) begin
            apply(1, 0, 0, 0, 0, 6'b100100);
            check("idle we", 32'(we), 0);
            check("idle wez", 32'(wez), 0);
            check("idle pc_en", 32'(pc_en), 0);
            check("idle count", 32'(instr_count), 0);
            check("idle busy", 32'(busy), 0);
            check("idle halted", 32'(halted), 0);
        end

        for (int i = 0; i < 20; i++) begin
            apply(1, tbl[i].rn, tbl[i].sp, tbl[i].st, tbl[i].z, tbl[i].op);
            check($sformatf("tbl%0d pc_en", i), 32'(pc_en), 32'(tbl[i].pc_en));
            check($sformatf("tbl%0d we", i), 32'(we), 32'(tbl[i].we));
            check($sformatf("tbl%0d wez", i), 32'(wez), 32'(tbl[i].wez));
            check($sformatf("tbl%0d s_inc", i), 32'(s_inc), 32'(tbl[i].s_inc));
            check($sformatf("tbl%0d s_inm", i), 32'(s_inm), 32'(tbl[i].s_inm));
            check($sformatf("tbl%0d ALUOp", i), 32'(ALUOp), 32'(tbl[i].alu));
            check($sformatf("tbl%0d busy", i), 32'(busy), 32'(tbl[i].busy));
            check($sformatf("tbl%0d halted", i), 32'(halted), 32'(tbl[i].halted));
            check($sformatf("tbl%0d illegal", i), 32'(illegal), 32'(tbl[i].ill));
            check($sformatf("tbl%0d count", i), 32'(instr_count), 32'(tbl[i].cnt));
        end

        // Reset clears the sticky flag and the counter.
        apply(0, 0, 0, 0, 0, 6'b100000);
        apply(1, 0, 0, 0, 0, 6'b100000);
        check("rst illegal", 32'(illegal), 0);
        check("rst count", 32'(instr_count), 0);
        check("rst busy", 32'(busy), 0);
        check("rst halted", 32'(halted), 0);

        // Counter wraps after 2^CNT_W retirements; stop cycle still retires.
        apply(1, 1, 0, 0, 0, 6'b100000);
        for (int i = 0; i < 16; i++) begin
            apply(1, 0, 0, 0, 0, 6'b100000);
            check($sformatf("wrap count %0d", i), 32'(instr_count), 32'(i));
        end
        apply(1, 0, 1, 0, 0, 6'b100000);
        check("wrap to zero", 32'(instr_count), 0);
        check("stop pc_en", 32'(pc_en), 1);
        apply(1, 0, 0, 0, 0, 6'b100000);
        check("stop halted", 32'(halted), 1);
        check("stop retired", 32'(instr_count), 1);

        // Randomized run against the model.
        apply(0, 0, 0, 0, 0, 6'b000000);
        ms = 0; mskip = 0; mill = 0; mcnt = 0;
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0: rop = 6'($urandom_range(0, 63));
                1: rop = 6'($urandom_range(0, 3));
                2: rop = 6'($urandom_range(32, 63));
                default: rop = 6'($urandom_range(16, 19));
            endcase
            apply(($urandom_range(0, 99) != 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 1)), rop);
            model_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
